imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Owns the single-port synchronous instruction memory (prgrom-class BRAM, 1-cycle read latency).
- Shares that memory between the instruction-fetch stage (read-only, every cycle) and the UART program loader (sequential word writes).
- Sequences the hand-over: stalls fetch, drains the in-flight read, accepts the load, then pulses a restart so fetch resumes from PC 0.

Parameters:
- ADDR_WIDTH, 14, word-address width; memory depth is 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, instruction word width (equals `ISA_WIDTH).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block.
- fetch_req  in  1  fetch stage requests a read this cycle.
- fetch_addr  in  ADDR_WIDTH  word address (PC[15:2]).
- fetch_gnt  out  1  read issued to memory this cycle.
- fetch_rvalid  out  1  fetch_rdata valid (read issued the previous cycle).
- fetch_rdata  out  DATA_WIDTH  instruction word; passthrough of mem_rdata.
- load_start  in  1  pulse; begin a program-load session.
- load_valid  in  1  loader presents a word.
- load_addr  in  ADDR_WIDTH  word address of the presented word.
- load_data  in  DATA_WIDTH  word to write.
- load_ready  out  1  arbiter accepts the word this cycle.
- load_done  in  1  pulse; session finished.
- load_count  out  ADDR_WIDTH+1  words written this session.
- load_err  out  1  sticky session error.
- cpu_stall  out  1  hold PC and pipeline.
- cpu_restart  out  1  one-cycle pulse; force PC to 0.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory word address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data, 1 cycle after mem_en with mem_we=0.

Behaviour:
- States: RUN, DRAIN, LOAD, RESTART.
- Reset (reset==0) applies from any state, including mid-LOAD. It forces state=RUN, fetch_rvalid=0, load_count=0, load_err=0 and cpu_restart=0. Combinational outputs follow RUN: cpu_stall=0, load_ready=0.

RUN:
- fetch_gnt = fetch_req & ~load_start.
- When granted: mem_en=1, mem_we=0, mem_addr=fetch_addr.
- load_start=1: next state DRAIN; load_count and load_err are cleared at that edge.
- load_start has priority over fetch_req in the same cycle: no grant, and cpu_stall=1 that cycle.

DRAIN:
- Exactly 1 cycle; fetch_gnt=0, cpu_stall=1.
- The pending read completes (fetch_rvalid may be 1 here).
- Next state is LOAD.

LOAD:
- cpu_stall=1, fetch_gnt=0.
- load_ready = ~load_done & (load_count < 2^ADDR_WIDTH).
- Write occurs when load_valid & load_ready & (load_addr == load_count[ADDR_WIDTH-1:0]): mem_en=1, mem_we=1, mem_addr=load_addr, mem_wdata=load_data, and load_count increments.
- load_valid & load_ready with a non-sequential address: the handshake completes (word consumed) but nothing is written, load_count is unchanged and load_err is set.
- Memory full: when load_count == 2^ADDR_WIDTH, load_ready=0. load_count never wraps.
- load_done=1: next state RESTART. A load_valid in the same cycle is not accepted.
- If load_done arrives with load_count==0, load_err is set.

RESTART:
- Exactly 1 cycle; cpu_restart=1, cpu_stall=1.
- Next state is RUN.

General rules:
- fetch_rvalid is a register: fetch_rvalid <= fetch_gnt.
- fetch_rdata = mem_rdata, combinational.
- load_start is ignored outside RUN. load_done is ignored outside LOAD.
- load_err holds until the next accepted load_start or reset.
- All memory-port outputs are 0 whenever they are not driven by the rules above.

Decomposition:
- definitions.v gains: state encodings (IMEM_RUN=2'd0, IMEM_DRAIN=2'd1, IMEM_LOAD=2'd2, IMEM_RESTART=2'd3) and `IMEM_ADDR_WIDTH 14.
- One natural sub-module, imem_load_counter, holds the saturating, clearable session word counter together with its sequential-address compare.

Test Plan:
- Reset and run:
  - Hold reset=0 for 2 cycles, then reset=1.
  - Drive fetch_req=1 with fetch_addr=0,1,2 and mem_rdata returning 0x11,0x22,0x33.
  - Require fetch_gnt=1 each cycle, with fetch_rvalid and fetch_rdata = 0x11/0x22/0x33 one cycle later.
- Hand-over:
  - Pulse load_start alongside fetch_req=1.
  - Require fetch_gnt=0 and cpu_stall=1 in that cycle, one DRAIN cycle next, then LOAD with load_ready=1.
- Sequential load:
  - Write addresses 0..3 with data 0xA0..0xA3, then pulse load_done.
  - Require 4 writes with mem_we=1 and load_count=4.
  - Require load_ready=0 in the load_done cycle, cpu_restart=1 for exactly the next cycle, then RUN with cpu_stall=0.
- Address error:
  - After 2 words, present load_addr=5.
  - Require no write, load_count=2, load_err=1 held through RESTART, and load_err cleared by the next load_start.
- Empty session and full memory:
  - load_start then immediate load_done: require load_err=1.
  - With ADDR_WIDTH=2, write 4 words: require load_ready=0 and load_count=4 with no wrap.
- Reset mid-LOAD:
  - Drive reset=0 after 3 words.
  - Require the next cycle to show RUN, load_count=0, load_err=0, cpu_stall=0, cpu_restart=0 and no memory write.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_arbiter_pkg;

   localparam int unsigned ImemAddrWidth = 14;
   localparam int unsigned ImemDataWidth = 32;

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StDrain   = 2'd1,
      StLoad    = 2'd2,
      StRestart = 2'd3
   } imem_state_e;

endpackage

// File: rtl/imem_load_counter.sv
// Saturating, clearable session word counter with sequential-address compare.
module imem_load_counter #(
   parameter int unsigned AddrWidth = 14
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clr_i,
   input  logic                 inc_i,
   input  logic [AddrWidth-1:0] addr_i,
   output logic [AddrWidth:0]   count_o,
   output logic                 full_o,
   output logic                 seq_o
);

   localparam logic [AddrWidth:0] FullCount = {1'b1, {AddrWidth{1'b0}}};

   logic [AddrWidth:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && !full_o) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign full_o  = (count_q == FullCount);
   assign seq_o   = (addr_i == count_q[AddrWidth-1:0]);

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction memory between fetch and the UART program loader.
module imem_arbiter
   import imem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = ImemAddrWidth,
   parameter int unsigned DATA_WIDTH = ImemDataWidth
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  fetch_req,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   output logic                  fetch_gnt,
   output logic                  fetch_rvalid,
   output logic [DATA_WIDTH-1:0] fetch_rdata,
   input  logic                  load_start,
   input  logic                  load_valid,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  load_ready,
   input  logic                  load_done,
   output logic [ADDR_WIDTH:0]   load_count,
   output logic                  load_err,
   output logic                  cpu_stall,
   output logic                  cpu_restart,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   imem_state_e state_d, state_q;
   logic        rvalid_d, rvalid_q;
   logic        err_d, err_q;
   logic        cnt_clr, cnt_inc, cnt_full, cnt_seq;

   imem_load_counter #(
      .AddrWidth(ADDR_WIDTH)
   ) u_load_counter (
      .clk_i  (clock),
      .rst_ni (reset),
      .clr_i  (cnt_clr),
      .inc_i  (cnt_inc),
      .addr_i (load_addr),
      .count_o(load_count),
      .full_o (cnt_full),
      .seq_o  (cnt_seq)
   );

   always_comb begin
      state_d     = state_q;
      err_d       = err_q;
      fetch_gnt   = 1'b0;
      load_ready  = 1'b0;
      cpu_stall   = 1'b0;
      cpu_restart = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      unique case (state_q)
         StRun: begin
            // A session request wins over fetch in the same cycle.
            if (load_start) begin
               cpu_stall = 1'b1;
               cnt_clr   = 1'b1;
               err_d     = 1'b0;
               state_d   = StDrain;
            end else if (fetch_req) begin
               fetch_gnt = 1'b1;
               mem_en    = 1'b1;
               mem_addr  = fetch_addr;
            end
         end
         StDrain: begin
            cpu_stall = 1'b1;
            state_d   = StLoad;
         end
         StLoad: begin
            cpu_stall  = 1'b1;
            load_ready = !load_done && !cnt_full;
            if (load_done) begin
               if (load_count == '0) begin
                  err_d = 1'b1;
               end
               state_d = StRestart;
            end else if (load_valid && load_ready) begin
               // Out-of-order words are consumed but dropped.
               if (cnt_seq) begin
                  mem_en    = 1'b1;
                  mem_we    = 1'b1;
                  mem_addr  = load_addr;
                  mem_wdata = load_data;
                  cnt_inc   = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StRestart: begin
            cpu_stall   = 1'b1;
            cpu_restart = 1'b1;
            state_d     = StRun;
         end
         default: state_d = StRun;
      endcase
      rvalid_d = fetch_gnt;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= StRun;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
      end
   end

   assign fetch_rvalid = rvalid_q;
   assign fetch_rdata  = mem_rdata;
   assign load_err     = err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: fetch reads scored against a reference memory image.
module tb_imem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        fetch_req, load_start, load_valid, load_done;
   logic [13:0] fetch_addr, load_addr;
   logic [31:0] load_data, mem_rdata, mem_wdata;
   logic        fetch_gnt, fetch_rvalid, load_ready, load_err, cpu_stall, cpu_restart;
   logic [31:0] fetch_rdata;
   logic [14:0] load_count;
   logic        mem_en, mem_we;
   logic [13:0] mem_addr;

   // Small-depth instance used for the memory-full case.
   logic        ls2, lv2, ld2, fr2;
   logic [1:0]  fa2, la2;
   logic [31:0] ldata2, rdata2_in;
   logic        gnt2, rv2, rdy2, err2, stall2, rst2_o, en2, we2;
   logic [31:0] rdata2, wdata2;
   logic [2:0]  cnt2;
   logic [1:0]  maddr2;

   logic [31:0] bmem    [16];
   logic [31:0] ref_mem [16];
   logic [31:0] sb_q[$];
   logic        pend;
   int          checks   = 0;
   int          failures = 0;

   always #5 clock = ~clock;

   imem_arbiter dut (
      .clock       (clock),
      .reset       (reset),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_gnt   (fetch_gnt),
      .fetch_rvalid(fetch_rvalid),
      .fetch_rdata (fetch_rdata),
      .load_start  (load_start),
      .load_valid  (load_valid),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .load_done   (load_done),
      .load_count  (load_count),
      .load_err    (load_err),
      .cpu_stall   (cpu_stall),
      .cpu_restart (cpu_restart),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   imem_arbiter #(
      .ADDR_WIDTH(2),
      .DATA_WIDTH(32)
   ) dut2 (
      .clock       (clock),
      .reset       (reset),
      .fetch_req   (fr2),
      .fetch_addr  (fa2),
      .fetch_gnt   (gnt2),
      .fetch_rvalid(rv2),
      .fetch_rdata (rdata2),
      .load_start  (ls2),
      .load_valid  (lv2),
      .load_addr   (la2),
      .load_data   (ldata2),
      .load_ready  (rdy2),
      .load_done   (ld2),
      .load_count  (cnt2),
      .load_err    (err2),
      .cpu_stall   (stall2),
      .cpu_restart (rst2_o),
      .mem_en      (en2),
      .mem_we      (we2),
      .mem_addr    (maddr2),
      .mem_wdata   (wdata2),
      .mem_rdata   (rdata2_in)
   );

   // Behavioural single-port BRAM, 1-cycle read latency.
   always @(posedge clock) begin
      if (mem_en) begin
         if (mem_we) bmem[mem_addr[3:0]] <= mem_wdata;
         else        mem_rdata <= bmem[mem_addr[3:0]];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then score the read that was issued before it.
   task automatic tick();
      logic [31:0] e;
      @(posedge clock);
      #1;
      chk("fetch_rvalid", {63'd0, fetch_rvalid}, {63'd0, pend});
      if (pend) begin
         if (sb_q.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
         end else begin
            e = sb_q.pop_front();
            chk("fetch_rdata", {32'd0, fetch_rdata}, {32'd0, e});
         end
      end
      pend = 1'b0;
   endtask

   task automatic fetch(input logic [13:0] a);
      fetch_req  = 1'b1;
      fetch_addr = a;
      #1;
      chk("fetch_gnt", {63'd0, fetch_gnt}, 64'd1);
      chk("fetch_mem_en", {63'd0, mem_en}, 64'd1);
      chk("fetch_mem_we", {63'd0, mem_we}, 64'd0);
      chk("fetch_mem_addr", {50'd0, mem_addr}, {50'd0, a});
      sb_q.push_back(ref_mem[a[3:0]]);
      pend = 1'b1;
      tick();
      fetch_req = 1'b0;
   endtask

   task automatic begin_load();
      fetch_req  = 1'b1;
      load_start = 1'b1;
      #1;
      chk("start_gnt", {63'd0, fetch_gnt}, 64'd0);
      chk("start_stall", {63'd0, cpu_stall}, 64'd1);
      chk("start_mem_en", {63'd0, mem_en}, 64'd0);
      tick();
      load_start = 1'b0;
      #1;
      chk("drain_gnt", {63'd0, fetch_gnt}, 64'd0);
      chk("drain_stall", {63'd0, cpu_stall}, 64'd1);
      chk("drain_ready", {63'd0, load_ready}, 64'd0);
      chk("drain_count", {49'd0, load_count}, 64'd0);
      chk("drain_err", {63'd0, load_err}, 64'd0);
      tick();
      fetch_req = 1'b0;
      #1;
      chk("load_ready", {63'd0, load_ready}, 64'd1);
      chk("load_stall", {63'd0, cpu_stall}, 64'd1);
   endtask

   task automatic load_word(input logic [13:0] a, input logic [31:0] d, input logic wr);
      load_valid = 1'b1;
      load_addr  = a;
      load_data  = d;
      #1;
      chk("word_ready", {63'd0, load_ready}, 64'd1);
      chk("word_we", {63'd0, mem_we}, {63'd0, wr});
      chk("word_en", {63'd0, mem_en}, {63'd0, wr});
      if (wr) begin
         chk("word_addr", {50'd0, mem_addr}, {50'd0, a});
         chk("word_data", {32'd0, mem_wdata}, {32'd0, d});
         ref_mem[a[3:0]] = d;
      end
      tick();
      load_valid = 1'b0;
   endtask

   task automatic end_load(input logic exp_err);
      load_done  = 1'b1;
      load_valid = 1'b1;
      load_addr  = load_count[13:0];
      #1;
      chk("done_ready", {63'd0, load_ready}, 64'd0);
      chk("done_we", {63'd0, mem_we}, 64'd0);
      tick();
      load_done  = 1'b0;
      load_valid = 1'b0;
      #1;
      chk("restart_pulse", {63'd0, cpu_restart}, 64'd1);
      chk("restart_stall", {63'd0, cpu_stall}, 64'd1);
      chk("restart_err", {63'd0, load_err}, {63'd0, exp_err});
      tick();
      #1;
      chk("run_restart", {63'd0, cpu_restart}, 64'd0);
      chk("run_stall", {63'd0, cpu_stall}, 64'd0);
      chk("run_err", {63'd0, load_err}, {63'd0, exp_err});
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         bmem[i]    = 32'hE000_0000 + i;
         ref_mem[i] = 32'hE000_0000 + i;
      end
      bmem[0] = 32'h11; bmem[1] = 32'h22; bmem[2] = 32'h33;
      ref_mem[0] = 32'h11; ref_mem[1] = 32'h22; ref_mem[2] = 32'h33;
      pend = 1'b0;
      reset = 1'b0;
      fetch_req = 1'b0; fetch_addr = '0; load_start = 1'b0; load_valid = 1'b0;
      load_addr = '0; load_data = '0; load_done = 1'b0;
      ls2 = 1'b0; lv2 = 1'b0; ld2 = 1'b0; fr2 = 1'b0; fa2 = '0; la2 = '0;
      ldata2 = '0; rdata2_in = '0;

      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("rst_count", {49'd0, load_count}, 64'd0);
      chk("rst_err", {63'd0, load_err}, 64'd0);
      chk("rst_stall", {63'd0, cpu_stall}, 64'd0);
      chk("rst_restart", {63'd0, cpu_restart}, 64'd0);
      chk("rst_ready", {63'd0, load_ready}, 64'd0);

      fetch(14'd0);
      fetch(14'd1);
      fetch(14'd2);

      begin_load();
      for (int i = 0; i < 4; i++) load_word(14'(i), 32'hA0 + i, 1'b1);
      chk("seq_count", {49'd0, load_count}, 64'd4);
      end_load(1'b0);
      for (int i = 0; i < 4; i++) fetch(14'(i));

      begin_load();
      load_word(14'd0, 32'hB0, 1'b1);
      load_word(14'd1, 32'hB1, 1'b1);
      load_word(14'd5, 32'hDEAD, 1'b0);
      chk("err_count", {49'd0, load_count}, 64'd2);
      chk("err_set", {63'd0, load_err}, 64'd1);
      end_load(1'b1);
      fetch(14'd1);

      begin_load();
      end_load(1'b1);

      begin_load();
      for (int i = 0; i < 3; i++) load_word(14'(i), 32'hC0 + i, 1'b1);
      reset = 1'b0;
      tick();
      #1;
      chk("mrst_count", {49'd0, load_count}, 64'd0);
      chk("mrst_err", {63'd0, load_err}, 64'd0);
      chk("mrst_stall", {63'd0, cpu_stall}, 64'd0);
      chk("mrst_restart", {63'd0, cpu_restart}, 64'd0);
      chk("mrst_we", {63'd0, mem_we}, 64'd0);
      reset = 1'b1;
      fetch(14'd0);
      fetch(14'd2);

      ls2 = 1'b1;
      tick();
      ls2 = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         lv2 = 1'b1;
         la2 = 2'(i);
         ldata2 = 32'hF0 + i;
         #1;
         chk("full_ready", {63'd0, rdy2}, 64'd1);
         chk("full_we", {63'd0, we2}, 64'd1);
         tick();
      end
      la2 = 2'd0;
      #1;
      chk("full_ready_low", {63'd0, rdy2}, 64'd0);
      chk("full_count", {61'd0, cnt2}, 64'd4);
      chk("full_no_we", {63'd0, we2}, 64'd0);
      chk("full_no_err", {63'd0, err2}, 64'd0);
      tick();
      lv2 = 1'b0;
      #1;
      chk("full_no_wrap", {61'd0, cnt2}, 64'd4);
      ld2 = 1'b1;
      tick();
      ld2 = 1'b0;
      #1;
      chk("full_restart", {63'd0, rst2_o}, 64'd1);
      tick();

      chk("sb_drained", {32'd0, 32'(sb_q.size())}, 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
